// File: rtl/mag_packet_serializer.sv
// Captures tagged 80-bit magnetometer words into a small FIFO and streams each
// one out as 10 MSB-first bytes over a valid/ready handshake, counting overflow drops.
module mag_packet_serializer #(
    parameter int          DEPTH = 4,
    parameter logic [7:0]  TAG   = 8'h4d
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] data_in,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [4:0]  fifo_count,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [79:0] r_prev_word;
    logic [79:0] r_mem [0:DEPTH-1];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [4:0]  r_count;
    logic [79:0] r_shreg;
    logic [3:0]  r_byte_idx;
    logic        r_overflow;
    logic [7:0]  r_drop_count;

    logic w_new;
    logic w_full;
    logic w_accept;
    logic w_last;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_new    = (data_in != r_prev_word) && (data_in[7:0] == TAG);
    assign w_full   = (r_count == DEPTH_C);
    assign w_accept = (r_state == SEND) && byte_ready;
    assign w_last   = (r_byte_idx == 4'd9);
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign w_push   = w_new && (!w_full || w_pop);
    assign w_drop   = w_new && w_full && !w_pop;

    assign byte_out   = r_shreg[79:72];
    assign byte_valid = (r_state == SEND);
    assign busy       = (r_state == SEND);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and pop decision
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != 5'd0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (w_accept && w_last) begin
                    if (r_count != 5'd0) begin
                        w_pop       = 1'b1;
                        w_state_nxt = SEND;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = SEND;
                end
            end
            default: begin
                w_pop       = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FIFO storage; emptiness is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= data_in;
        end
    end

    // Change detector, FIFO pointers/count and overflow statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_word  <= 80'd0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= 5'd0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_prev_word <= data_in;
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'd255) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    // Output shift register: load on pop, shift on every non-final accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg    <= 80'd0;
            r_byte_idx <= 4'd0;
        end else if (w_pop) begin
            r_shreg    <= r_mem[r_head];
            r_byte_idx <= 4'd0;
        end else if (w_accept && !w_last) begin
            r_shreg    <= {r_shreg[71:0], 8'h00};
            r_byte_idx <= r_byte_idx + 4'd1;
        end
    end

endmodule
